// File: rtl/debug_data_receiver.sv
// rtl/debug_data_receiver.sv - deserializer for the 40-bit debug serial link
//
// Purpose:
//   Synchronizes the asynchronous link clock, data and frame lines into clk,
//   reassembles MSB-first WIDTH-bit words, and presents each completed word
//   on a valid/ack holding register. It flags a dropped word (overrun) and an
//   aborted frame (frame_error).
//
// Optional feature:
//   DEBUG_RX_TIMEOUT_EN - when defined, a frame whose link clock stalls for
//   TIMEOUT_CYCLES clk cycles is aborted.
//
// Ports:
//   clk          system clock; all logic on posedge
//   reset_n      asynchronous active-low reset
//   sclk         link clock (async); data is sampled on its rising edge
//   sdata        link serial data, MSB first
//   sframe       high for the whole frame, low between frames
//   data_out     last accepted word
//   data_valid   data_out holds an unacknowledged word
//   data_ack     consumer accepts data_out
//   overrun      sticky; a complete frame was dropped while data_valid was high
//   frame_error  one-clk pulse on an aborted frame
//   busy         high while a frame is being received or drained
module debug_data_receiver #(
  parameter int unsigned WIDTH          = 40,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             sframe,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             overrun,
  output logic             frame_error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  // Bit 0 is the first synchronizer stage, bit 1 the synced value and bit 2
  // the previous synced value used for edge detection.
  logic [2:0]       sclk_sync_q, sclk_sync_d;
  logic [1:0]       sdata_sync_q, sdata_sync_d;
  logic [2:0]       sframe_sync_q, sframe_sync_d;
  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_error_q, frame_error_d;

  logic sclk_rise, sframe_rise, sframe_s, sdata_s;

`ifdef DEBUG_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);
  logic [IW-1:0] idle_q, idle_d;
`else
  // TIMEOUT_CYCLES only sizes logic when the idle timeout is compiled in.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout_unused
  end
`endif

  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sframe_rise = sframe_sync_q[1] & ~sframe_sync_q[2];
  assign sframe_s    = sframe_sync_q[1];
  assign sdata_s     = sdata_sync_q[1];

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], sclk};
    sdata_sync_d  = {sdata_sync_q[0], sdata};
    sframe_sync_d = {sframe_sync_q[1:0], sframe};
    state_d       = state_q;
    count_d       = count_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    overrun_d     = overrun_q;
    frame_error_d = 1'b0;
`ifdef DEBUG_RX_TIMEOUT_EN
    idle_d        = idle_q;
`endif

    if (data_ack && data_valid_q) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sframe_rise) begin
          state_d = RECV;
          count_d = '0;
          shift_d = '0;
`ifdef DEBUG_RX_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end

      RECV: begin
`ifdef DEBUG_RX_TIMEOUT_EN
        idle_d = sclk_rise ? '0 : idle_q + IW'(1);
`endif
        // Completion is checked before sframe so a word finished just ahead
        // of the frame falling is never mistaken for an aborted frame.
        if (count_q == COUNT_FULL) begin
          // An ack in this same cycle frees the holding register for the new word.
          if (!data_valid_q || data_ack) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          state_d = WAIT_END;
        end else if (!sframe_s) begin
          // A bit arriving together with the frame falling is dropped here.
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end
`ifdef DEBUG_RX_TIMEOUT_EN
        else if (idle_q == IDLE_LIMIT) begin
          frame_error_d = 1'b1;
          state_d       = WAIT_END;
        end
`endif
        else if (sclk_rise) begin
          shift_d = {shift_q[WIDTH-2:0], sdata_s};
          count_d = count_q + CW'(1);
        end
      end

      WAIT_END: begin
        if (!sframe_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q   <= '0;
      sdata_sync_q  <= '0;
      sframe_sync_q <= '0;
      state_q       <= IDLE;
      count_q       <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef DEBUG_RX_TIMEOUT_EN
      idle_q        <= '0;
`endif
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      sdata_sync_q  <= sdata_sync_d;
      sframe_sync_q <= sframe_sync_d;
      state_q       <= state_d;
      count_q       <= count_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
`ifdef DEBUG_RX_TIMEOUT_EN
      idle_q        <= idle_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q == RECV) || (state_q == WAIT_END);

endmodule

// File: doc/debug_data_receiver.md
# debug_data_receiver

Deserializer for the 40-bit debug serial link. It sits at the capture end of the debug link, in the host-side or logic-analyzer-side FPGA, and runs on its own clock, unrelated to the link clock. It synchronizes the link's clock, data and frame lines and reassembles MSB-first 40-bit words. Each completed word is presented on a valid/ack holding register; overrun and framing errors are flagged.

## Interface
Parameters:
- WIDTH, 40, bits per frame; the counter is sized for 0..WIDTH.
- TIMEOUT_CYCLES, 4096, clk cycles allowed between link clock edges inside a frame. Used only with DEBUG_RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on posedge. One clock; reset is asynchronous and active-low.
- reset_n  input  1  asynchronous active-low reset; release is synchronous to clk.
- sclk  input  1  link clock, asynchronous. The transmitter changes sdata on the falling edge, so the receiver samples on the rising edge.
- sdata  input  1  link serial data, MSB first.
- sframe  input  1  high for the whole 40-bit frame; low between frames.
- data_out  output  WIDTH  last accepted word.
- data_valid  output  1  data_out holds an unacknowledged word.
- data_ack  input  1  consumer accepts data_out.
- overrun  output  1  sticky; set when a complete frame was dropped because data_valid was high.
- frame_error  output  1  one-clk pulse on an aborted frame.
- busy  output  1  high in states RECV and WAIT_END.

## Operation
- **Synchronizers:** sclk, sdata and sframe each pass through a 2-FF synchronizer. One extra sclk stage provides edge detection.
  - sclk_rise = synced sclk high and previous sample low.
  - sframe_rise is detected the same way.
- **States:**
  - IDLE: sframe_rise goes to RECV; count=0 and the shift register clears.
  - RECV, on sclk_rise with synced sframe high: shift = {shift[WIDTH-2:0], sdata_sync}; count+1.
    - When count reaches WIDTH and data_valid=0, or data_ack is high that cycle: data_out<=shift, data_valid<=1. Then go to WAIT_END.
    - When count reaches WIDTH and data_valid=1 with no ack: word dropped, overrun<=1. Then go to WAIT_END.
  - RECV, synced sframe low with count<WIDTH: frame_error pulse, partial word discarded, go to IDLE. If sframe falls in the same cycle as an sclk_rise, that bit is discarded.
  - WAIT_END: ignores sclk; goes to IDLE when synced sframe is low. Extra edges past WIDTH are ignored and raise no error.
- **Handshake:**
  - data_ack high while data_valid=1 gives data_valid=0 and overrun=0 on the next clk.
  - Ack in the same cycle as a frame completion: the new word loads, data_valid stays 1, overrun is not set.
  - data_ack while data_valid=0 is ignored.
- **Reset:** asserting reset_n mid-frame returns to IDLE immediately. A frame already in flight at release is not captured, because sframe_rise is needed.

## Timing
- Reset values:
  - data_out=0, data_valid=0, overrun=0, frame_error=0, busy=0.
  - State IDLE, count=0, all synchronizer flops 0.
- sclk high and low phases must each be ≥3 clk periods. sdata must be stable ≥3 clk periods either side of the sclk rising edge.
- Latency from the sclk pin rising edge to the shift-register update is 3 clk cycles: 2 synchronizer cycles plus 1 edge-detect/shift cycle.
- Latency from the last sclk rising edge to data_valid high is 4 clk cycles.
- sframe must rise ≥3 clk before the first sclk rising edge. It must fall ≥3 clk after the last sclk rising edge.
- frame_error is exactly 1 clk wide. busy deasserts in the same cycle as the return to IDLE.

## Configuration
- DEBUG_RX_TIMEOUT_EN defined:
  - In RECV, an idle counter clears on every sclk_rise and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: frame_error pulse, partial word discarded, go to WAIT_END.
- Not defined: no idle counter. RECV waits for sclk or sframe indefinitely, and TIMEOUT_CYCLES is unused.

## Test plan
- Single frame 0xA999999991, sclk = clk/8, then data_ack 2 cycles later:
  - data_out=0xA999999991 with data_valid high 4 clk after the 40th rising edge.
  - data_valid low 1 clk after the ack; overrun=0.
- Two frames 0xA999999981 then 0xE999999993, with no ack between them:
  - data_out stays 0xA999999981 and overrun=1.
  - A subsequent ack clears both data_valid and overrun.
- Ack asserted in the same cycle the second frame completes: data_out=0xE999999993, data_valid=1, overrun=0.
- sframe dropped after 17 bits: frame_error pulses once, data_valid stays 0, state IDLE. The next full frame is received correctly.
- reset_n pulsed low after bit 20 with sframe kept high: outputs return to reset values and no word is captured until the next sframe_rise. With DEBUG_RX_TIMEOUT_EN and TIMEOUT_CYCLES=64, sclk stopped after bit 10 gives a frame_error pulse at 64 idle clk, then WAIT_END until sframe falls.
